sm_display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's multi-digit 7-segment display. It holds a double-buffered copy of the hex value to show and walks the digits one at a time. For each digit it drives the decoded segment pattern and a one-hot digit select, with PWM brightness and an anti-ghosting dead gap between digits. It sits between the core's debug/register output and the board IO pins, and replaces free-running ad-hoc digit muxing.

---
 rtl/sm_display_pkg.sv | 19 +
 rtl/sm_display_scan_prescaler.sv | 29 ++
 rtl/sm_display_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sm_display_scan_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sm_display_pkg.sv
// rtl/sm_display_pkg.sv - shared state encoding, PWM depth and hex-to-7-segment decode
package sm_display_pkg;

    localparam logic [0:0] S_ON  = 1'b0;
    localparam logic [0:0] S_GAP = 1'b1;

    localparam int PWM_STEPS = 16;

    // seg[6:0] = gfedcba, active-high
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return SEG_LUT[hex];
    endfunction

endpackage

// File: rtl/sm_display_scan_prescaler.sv
// rtl/sm_display_scan_prescaler.sv - free-running divider producing a one-clk scan tick every PRESCALE clk
module sm_scan_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(PRESCALE - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sm_display_scan_ctrl.sv
// rtl/sm_display_scan_ctrl.sv - multiplexed 7-segment scan controller with PWM, dead gap and frame-aligned commit
// Optional leading-zero blanking: SM_DISPLAY_SCAN_LZ_BLANK_EN
module sm_display_scan_ctrl
    import sm_display_pkg::*;
#(
    parameter int DIGITS    = 3,
    parameter int PRESCALE  = 1000,
    parameter int GAP_TICKS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  load,
    input  logic [3:0]            brightness,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done,
    output logic                  pending_valid
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    logic                tick;
    logic [0:0]          state_q, state_d;
    logic [3:0]          phase_q, phase_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [3:0]          bright_q, bright_d;
    logic                resync_q;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [4*DIGITS-1:0] pending_q, pending_d;
    logic                pend_valid_q, pend_valid_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic                frame_done_q, frame_done_d;

    logic [3:0]          bright_eff;
    logic                slot_end;
    logic                lit;
    logic [3:0]          nib;
    logic                blank_cur;
    logic [DIGITS-1:0]   sel_onehot;
    logic [DIGITS-1:0]   lz_blank;

    sm_scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // The first cycle out of reset is the entry to phase 0 of slot 0, so
    // brightness is taken live there rather than from the cleared register.
    assign bright_eff = resync_q ? brightness : bright_q;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        gap_d        = gap_q;
        idx_d        = idx_q;
        bright_d     = bright_eff;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        frame_done_d = 1'b0;
        slot_end     = 1'b0;

        if (tick) begin
            if (state_q == S_ON) begin
                if (phase_q == 4'(PWM_STEPS - 1)) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end else begin
                if (gap_q == GW'(GAP_TICKS - 1)) begin
                    slot_end = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
        end

        if (slot_end) begin
            state_d  = S_ON;
            phase_d  = '0;
            bright_d = brightness;
            if (idx_q == IW'(DIGITS - 1)) begin
                idx_d        = '0;
                frame_done_d = 1'b1;
                if (pend_valid_q) begin
                    shadow_d     = pending_q;
                    pend_valid_d = 1'b0;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // A load coinciding with a commit lands after it: the commit already took the old value.
        if (load) begin
            pending_d    = digits_in;
            pend_valid_d = 1'b1;
        end
    end

`ifdef SM_DISPLAY_SCAN_LZ_BLANK_EN
    logic zero_run;

    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run & (shadow_q[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        nib        = '0;
        blank_cur  = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib           = shadow_q[4*i +: 4];
                blank_cur     = lz_blank[i];
                sel_onehot[i] = 1'b1;
            end
        end
        lit       = (state_q == S_ON) && (phase_q < bright_eff);
        seg_d     = (lit && !blank_cur) ? hex_to_seg(nib) : 7'h00;
        dig_sel_d = lit ? sel_onehot : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ON;
            phase_q      <= '0;
            gap_q        <= '0;
            idx_q        <= '0;
            bright_q     <= '0;
            resync_q     <= 1'b1;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= '0;
            dig_sel_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            gap_q        <= gap_d;
            idx_q        <= idx_d;
            bright_q     <= bright_d;
            resync_q     <= 1'b0;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg           = seg_q;
    assign dig_sel       = dig_sel_q;
    assign frame_done    = frame_done_q;
    assign pending_valid = pend_valid_q;

endmodule

// File: tb/tb_sm_display_scan_ctrl.sv
// tb/tb_sm_display_scan_ctrl.sv - directed self-checking bench for sm_display_scan_ctrl
module tb_sm_display_scan_ctrl;

    localparam int DIGITS    = 3;
    localparam int PRESCALE  = 4;
    localparam int GAP_TICKS = 1;
    localparam int SLOT      = (16 + GAP_TICKS) * PRESCALE;
    localparam int FRAME     = DIGITS * SLOT;

`ifdef SM_DISPLAY_SCAN_LZ_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h00;
`else
    localparam logic [6:0] LZ_SEG = 7'h3F;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [11:0] digits_in;
    logic [3:0]  brightness;
    logic [6:0]  seg;
    logic [2:0]  dig_sel;
    logic        frame_done;
    logic        pending_valid;

    int n_cmp = 0;
    int n_bad = 0;
    bit multi_hot = 1'b0;

    always #5 clk = ~clk;

    sm_display_scan_ctrl #(
        .DIGITS    (DIGITS),
        .PRESCALE  (PRESCALE),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .digits_in     (digits_in),
        .load          (load),
        .brightness    (brightness),
        .seg           (seg),
        .dig_sel       (dig_sel),
        .frame_done    (frame_done),
        .pending_valid (pending_valid)
    );

    always @(negedge clk) begin
        if (rst === 1'b0 && !$onehot0(dig_sel)) multi_hot = 1'b1;
    end

    // Waits for the next lit digit, then counts its lit and following dark cycles.
    task automatic measure_slot(output logic [2:0] sel, output logic [6:0] sg,
                                output int lit, output int dark, output bit seg_stable);
        int n;
        n = 0; lit = 0; dark = 0; seg_stable = 1'b1;
        while (dig_sel == 3'b000 && n < 400) begin @(negedge clk); n++; end
        sel = dig_sel;
        sg  = seg;
        while (sel != 3'b000 && dig_sel == sel && lit < 400) begin
            if (seg !== sg) seg_stable = 1'b0;
            lit++;
            @(negedge clk);
        end
        while (dig_sel == 3'b000 && dark < 400) begin dark++; @(negedge clk); end
    endtask

    task automatic wait_frame_done(input int lim, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < lim && !seen; n++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [2:0] sel; logic [6:0] sg; int lit, dark; bit st;
        rst = 1'b1; load = 1'b0; digits_in = '0; brightness = 4'd15;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (seg !== 7'h00) begin n_bad++; $display("FAIL rst_seg: got %h expected 00", seg); end
        n_cmp++; if (dig_sel !== 3'b000) begin n_bad++; $display("FAIL rst_dig_sel: got %b expected 000", dig_sel); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
        n_cmp++; if (pending_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pending_valid: got %b expected 0", pending_valid); end
        rst = 1'b0;
        measure_slot(sel, sg, lit, dark, st);
        n_cmp++; if (sel !== 3'b001) begin n_bad++; $display("FAIL start_sel: got %b expected 001", sel); end
        n_cmp++; if (sg !== 7'h3F) begin n_bad++; $display("FAIL start_seg: got %h expected 3F", sg); end
        n_cmp++; if (lit != 60) begin n_bad++; $display("FAIL start_lit: got %0d expected 60", lit); end
        n_cmp++; if (dark != 8) begin n_bad++; $display("FAIL start_dark: got %0d expected 8", dark); end
        n_cmp++; if (!st) begin n_bad++; $display("FAIL start_seg_stable: got 0 expected 1"); end
        n_cmp++; if (dig_sel !== 3'b010) begin n_bad++; $display("FAIL start_next_sel: got %b expected 010", dig_sel); end
    endtask

    task automatic test_commit;
        logic [2:0] sel; logic [6:0] sg; int lit, dark; bit st, seen, bad_seg;
        logic [2:0] exp_sel [3];
        logic [6:0] exp_seg [3];
        exp_sel = '{3'b001, 3'b010, 3'b100};
        exp_seg = '{7'h4F, 7'h5B, 7'h06};
        repeat (5) @(negedge clk);
        load = 1'b1; digits_in = 12'h123;
        @(negedge clk);
        load = 1'b0;
        n_cmp++; if (pending_valid !== 1'b1) begin n_bad++; $display("FAIL commit_pv_set: got %b expected 1", pending_valid); end
        seen = 1'b0; bad_seg = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
            else if (dig_sel != 3'b000 && seg !== 7'h3F) bad_seg = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL commit_frame_done: got 0 expected 1"); end
        n_cmp++; if (bad_seg) begin n_bad++; $display("FAIL commit_seg_held: got changed expected 3F until commit"); end
        n_cmp++; if (pending_valid !== 1'b0) begin n_bad++; $display("FAIL commit_pv_clear: got %b expected 0", pending_valid); end
        for (int i = 0; i < 3; i++) begin
            measure_slot(sel, sg, lit, dark, st);
            n_cmp++; if (sel !== exp_sel[i]) begin n_bad++; $display("FAIL commit_sel%0d: got %b expected %b", i, sel, exp_sel[i]); end
            n_cmp++; if (sg !== exp_seg[i]) begin n_bad++; $display("FAIL commit_seg%0d: got %h expected %h", i, sg, exp_seg[i]); end
        end
    endtask

    task automatic test_pwm;
        logic [2:0] sel; logic [6:0] sg; int lit, dark, lit_cnt; bit st, seen;
        brightness = 4'd4;
        measure_slot(sel, sg, lit, dark, st);
        n_cmp++; if (lit != 60) begin n_bad++; $display("FAIL pwm_midslot_lit: got %0d expected 60", lit); end
        n_cmp++; if (dark != 8) begin n_bad++; $display("FAIL pwm_midslot_dark: got %0d expected 8", dark); end
        measure_slot(sel, sg, lit, dark, st);
        n_cmp++; if (sel !== 3'b010) begin n_bad++; $display("FAIL pwm4_sel: got %b expected 010", sel); end
        n_cmp++; if (lit != 16) begin n_bad++; $display("FAIL pwm4_lit: got %0d expected 16", lit); end
        n_cmp++; if (dark != 52) begin n_bad++; $display("FAIL pwm4_dark: got %0d expected 52", dark); end
        measure_slot(sel, sg, lit, dark, st);
        n_cmp++; if (lit != 16) begin n_bad++; $display("FAIL pwm4_lit2: got %0d expected 16", lit); end
        brightness = 4'd0;
        wait_frame_done(FRAME + 10, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL pwm0_frame_done: got 0 expected 1"); end
        lit_cnt = 0;
        for (int n = 0; n < FRAME; n++) begin
            @(negedge clk);
            if (dig_sel != 3'b000) lit_cnt++;
        end
        n_cmp++; if (lit_cnt != 0) begin n_bad++; $display("FAIL pwm0_dark_frame: got %0d lit cycles expected 0", lit_cnt); end
        brightness = 4'd15;
    endtask

    task automatic test_coincident;
        logic [2:0] sel; logic [6:0] sg; int lit, dark; bit st, seen;
        logic [6:0] exp_a [3];
        logic [6:0] exp_b [3];
        exp_a = '{7'h4F, 7'h5B, 7'h06};
        exp_b = '{7'h39, 7'h7C, 7'h77};
        wait_frame_done(2 * FRAME + 10, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL coin_sync: got 0 expected 1"); end
        load = 1'b1; digits_in = 12'h123;
        @(negedge clk);
        load = 1'b0;
        repeat (FRAME - 2) @(negedge clk);
        load = 1'b1; digits_in = 12'hABC;
        @(negedge clk);
        load = 1'b0;
        n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL coin_frame_period: got %b expected 1", frame_done); end
        n_cmp++; if (pending_valid !== 1'b1) begin n_bad++; $display("FAIL coin_pv_kept: got %b expected 1", pending_valid); end
        for (int i = 0; i < 3; i++) begin
            measure_slot(sel, sg, lit, dark, st);
            n_cmp++; if (sg !== exp_a[i]) begin n_bad++; $display("FAIL coin_old_seg%0d: got %h expected %h", i, sg, exp_a[i]); end
        end
        n_cmp++; if (pending_valid !== 1'b0) begin n_bad++; $display("FAIL coin_pv_clear: got %b expected 0", pending_valid); end
        for (int i = 0; i < 3; i++) begin
            measure_slot(sel, sg, lit, dark, st);
            n_cmp++; if (sg !== exp_b[i]) begin n_bad++; $display("FAIL coin_new_seg%0d: got %h expected %h", i, sg, exp_b[i]); end
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        load = 1'b1; digits_in = 12'h456;
        @(negedge clk);
        load = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 2 * SLOT && !seen; n++) begin
            if (dig_sel === 3'b010) seen = 1'b1; else @(negedge clk);
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL rmid_reach_idx1: got 0 expected 1"); end
        n_cmp++; if (pending_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pv_before: got %b expected 1", pending_valid); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (seg !== 7'h00) begin n_bad++; $display("FAIL rmid_seg: got %h expected 00", seg); end
        n_cmp++; if (dig_sel !== 3'b000) begin n_bad++; $display("FAIL rmid_dig_sel: got %b expected 000", dig_sel); end
        n_cmp++; if (pending_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_pv: got %b expected 0", pending_valid); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rmid_frame_done: got %b expected 0", frame_done); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (dig_sel !== 3'b001) begin n_bad++; $display("FAIL rmid_restart_sel: got %b expected 001", dig_sel); end
        n_cmp++; if (seg !== 7'h3F) begin n_bad++; $display("FAIL rmid_restart_seg: got %h expected 3F", seg); end
    endtask

    task automatic test_lz;
        logic [2:0] sel; logic [6:0] sg; int lit, dark; bit st, seen;
        logic [6:0] exp_seg [3];
        exp_seg = '{7'h77, LZ_SEG, LZ_SEG};
        load = 1'b1; digits_in = 12'h00A;
        @(negedge clk);
        load = 1'b0;
        wait_frame_done(FRAME + 10, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL lz_frame_done: got 0 expected 1"); end
        for (int i = 0; i < 3; i++) begin
            measure_slot(sel, sg, lit, dark, st);
            n_cmp++; if (sg !== exp_seg[i]) begin n_bad++; $display("FAIL lz_seg%0d: got %h expected %h", i, sg, exp_seg[i]); end
            n_cmp++; if (lit != 60) begin n_bad++; $display("FAIL lz_lit%0d: got %0d expected 60", i, lit); end
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; digits_in = '0; brightness = 4'd15;
        test_reset();
        test_commit();
        test_pwm();
        test_coincident();
        test_reset_mid();
        test_lz();
        n_cmp++; if (multi_hot) begin n_bad++; $display("FAIL onehot0_dig_sel: got multi-hot expected at most one bit"); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
